// File: rtl/multi_alarm_clock.sv
// BCD time-of-day clock with a seconds prescaler, digit-wise time/alarm loading,
// 12/24-hour display and N independent alarms with snooze and auto-timeout.
module multi_alarm_clock #(
    parameter int TICK_DIV   = 50000000,
    parameter int N_ALARM    = 2,
    parameter int SNOOZE_MIN = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               mode_12h,
    input  logic               set_time,
    input  logic               set_alarm,
    input  logic [1:0]         alarm_sel,
    input  logic [1:0]         digit_sel,
    input  logic [3:0]         load_val,
    input  logic               load_strobe,
    input  logic [N_ALARM-1:0] alarm_arm,
    input  logic               snooze,
    input  logic               dismiss,
    output logic [23:0]        time_bcd,
    output logic [15:0]        disp_bcd,
    output logic               pm,
    output logic [15:0]        alarm_bcd,
    output logic [N_ALARM-1:0] ringing,
    output logic               buzz,
    output logic               sec_tick
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, RING, SNOOZE} alarm_state_t;

    logic [PW-1:0] presc;
    logic [3:0]    sec_o, sec_t, min_o, min_t, hr_o, hr_t;
    logic [3:0]    n_sec_o, n_sec_t, n_min_o, n_min_t, n_hr_o, n_hr_t;
    logic          min_carry, hr_carry;
    logic [15:0]   alarm_time [N_ALARM];
    logic [15:0]   sel_alarm;
    logic          sel_valid;
    logic          time_wr, alarm_wr;
    logic [4:0]    hour, hour_12;

    alarm_state_t  state     [N_ALARM];
    alarm_state_t  state_n   [N_ALARM];
    logic [3:0]    snz_cnt   [N_ALARM];
    logic [3:0]    snz_cnt_n [N_ALARM];
    logic [5:0]    ring_cnt  [N_ALARM];
    logic [5:0]    ring_cnt_n[N_ALARM];

    // A digit write is legal only if the digit stays in range and the hour stays <= 23.
    function automatic logic write_ok(input logic [1:0] d, input logic [3:0] v,
                                      input logic [3:0] ht, input logic [3:0] ho);
        logic [7:0] hr;
        hr       = '0;
        write_ok = 1'b0;
        case (d)
            2'd0: write_ok = (v <= 4'd9);
            2'd1: write_ok = (v <= 4'd5);
            2'd2: begin
                hr       = 8'(ht) * 8'd10 + 8'(v);
                write_ok = (v <= 4'd9) && (hr <= 8'd23);
            end
            default: begin
                hr       = 8'(v) * 8'd10 + 8'(ho);
                write_ok = (v <= 4'd2) && (hr <= 8'd23);
            end
        endcase
    endfunction

    assign sec_tick = en && !set_time && (presc == PRESC_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            presc <= '0;
        else if (set_time)
            presc <= '0;
        else if (en)
            presc <= (presc == PRESC_MAX) ? '0 : presc + 1'b1;
    end

    always_comb begin
        n_sec_o   = sec_o;
        n_sec_t   = sec_t;
        n_min_o   = min_o;
        n_min_t   = min_t;
        n_hr_o    = hr_o;
        n_hr_t    = hr_t;
        min_carry = 1'b0;
        hr_carry  = 1'b0;
        if (sec_tick) begin
            if (sec_o == 4'd9) begin
                n_sec_o = 4'd0;
                if (sec_t == 4'd5) begin
                    n_sec_t   = 4'd0;
                    min_carry = 1'b1;
                end else begin
                    n_sec_t = sec_t + 4'd1;
                end
            end else begin
                n_sec_o = sec_o + 4'd1;
            end
        end
        if (min_carry) begin
            if (min_o == 4'd9) begin
                n_min_o = 4'd0;
                if (min_t == 4'd5) begin
                    n_min_t  = 4'd0;
                    hr_carry = 1'b1;
                end else begin
                    n_min_t = min_t + 4'd1;
                end
            end else begin
                n_min_o = min_o + 4'd1;
            end
        end
        if (hr_carry) begin
            if (hr_t == 4'd2 && hr_o == 4'd3) begin
                n_hr_t = 4'd0;
                n_hr_o = 4'd0;
            end else if (hr_o == 4'd9) begin
                n_hr_t = hr_t + 4'd1;
                n_hr_o = 4'd0;
            end else begin
                n_hr_o = hr_o + 4'd1;
            end
        end
    end

    always_comb begin
        sel_alarm = '0;
        sel_valid = 1'b0;
        for (int i = 0; i < N_ALARM; i++) begin
            if (alarm_sel == 2'(i)) begin
                sel_alarm = alarm_time[i];
                sel_valid = 1'b1;
            end
        end
    end

    assign alarm_bcd = sel_alarm;
    assign time_wr   = load_strobe && set_time && write_ok(digit_sel, load_val, hr_t, hr_o);
    assign alarm_wr  = load_strobe && !set_time && set_alarm && sel_valid &&
                       write_ok(digit_sel, load_val, sel_alarm[15:12], sel_alarm[11:8]);

    // While setting, seconds are pinned to zero and only explicit writes move hh:mm.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sec_o <= '0;
            sec_t <= '0;
            min_o <= '0;
            min_t <= '0;
            hr_o  <= '0;
            hr_t  <= '0;
        end else if (set_time) begin
            sec_o <= '0;
            sec_t <= '0;
            if (time_wr) begin
                case (digit_sel)
                    2'd0:    min_o <= load_val;
                    2'd1:    min_t <= load_val;
                    2'd2:    hr_o  <= load_val;
                    default: hr_t  <= load_val;
                endcase
            end
        end else begin
            sec_o <= n_sec_o;
            sec_t <= n_sec_t;
            min_o <= n_min_o;
            min_t <= n_min_t;
            hr_o  <= n_hr_o;
            hr_t  <= n_hr_t;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_ALARM; i++)
                alarm_time[i] <= '0;
        end else if (alarm_wr) begin
            for (int i = 0; i < N_ALARM; i++)
                if (alarm_sel == 2'(i))
                    alarm_time[i][{digit_sel, 2'b00} +: 4] <= load_val;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_ALARM; i++) begin
                state[i]    <= IDLE;
                snz_cnt[i]  <= '0;
                ring_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_ALARM; i++) begin
                state[i]    <= state_n[i];
                snz_cnt[i]  <= snz_cnt_n[i];
                ring_cnt[i] <= ring_cnt_n[i];
            end
        end
    end

    // Matches are checked against the post-tick time, so only a seconds rollover can trigger.
    always_comb begin
        for (int i = 0; i < N_ALARM; i++) begin
            state_n[i]    = state[i];
            snz_cnt_n[i]  = snz_cnt[i];
            ring_cnt_n[i] = ring_cnt[i];
            if (!alarm_arm[i]) begin
                state_n[i] = IDLE;
            end else begin
                case (state[i])
                    IDLE: begin
                        if (min_carry && alarm_time[i] == {n_hr_t, n_hr_o, n_min_t, n_min_o}) begin
                            state_n[i]    = RING;
                            ring_cnt_n[i] = '0;
                        end
                    end
                    RING: begin
                        if (dismiss) begin
                            state_n[i] = IDLE;
                        end else if (snooze) begin
                            state_n[i]   = SNOOZE;
                            snz_cnt_n[i] = 4'(SNOOZE_MIN);
                        end else if (sec_tick) begin
                            if (ring_cnt[i] == 6'd59)
                                state_n[i] = IDLE;
                            else
                                ring_cnt_n[i] = ring_cnt[i] + 6'd1;
                        end
                    end
                    SNOOZE: begin
                        if (dismiss) begin
                            state_n[i] = IDLE;
                        end else if (min_carry) begin
                            if (snz_cnt[i] == 4'd1) begin
                                state_n[i]    = RING;
                                snz_cnt_n[i]  = '0;
                                ring_cnt_n[i] = '0;
                            end else begin
                                snz_cnt_n[i] = snz_cnt[i] - 4'd1;
                            end
                        end
                    end
                    default: state_n[i] = IDLE;
                endcase
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_ALARM; i++)
            ringing[i] = (state[i] == RING);
    end

    assign buzz     = |ringing;
    assign time_bcd = {hr_t, hr_o, min_t, min_o, sec_t, sec_o};

    always_comb begin
        hour    = 5'(hr_t) * 5'd10 + 5'(hr_o);
        hour_12 = hour;
        if (hour == 5'd0)
            hour_12 = 5'd12;
        else if (hour > 5'd12)
            hour_12 = hour - 5'd12;
        pm = mode_12h && (hour >= 5'd12);
        if (!mode_12h)
            disp_bcd = {hr_t, hr_o, min_t, min_o};
        else if (hour_12 >= 5'd10)
            disp_bcd = {4'd1, 4'(hour_12 - 5'd10), min_t, min_o};
        else
            disp_bcd = {4'd0, 4'(hour_12), min_t, min_o};
    end

endmodule

// File: tb/tb_multi_alarm_clock.sv
// Directed bench for multi_alarm_clock: a digit-write/display vector table followed by
// hand-written sequences for rollover, alarm ring/snooze/timeout, disarm and async reset.
module tb_multi_alarm_clock;

    localparam int TD = 4;

    logic        clk = 1'b0;
    logic        rst, en, mode_12h, set_time, set_alarm;
    logic [1:0]  alarm_sel, digit_sel;
    logic [3:0]  load_val;
    logic        load_strobe;
    logic [1:0]  alarm_arm;
    logic        snooze, dismiss;
    logic [23:0] time_bcd;
    logic [15:0] disp_bcd, alarm_bcd;
    logic        pm, buzz, sec_tick;
    logic [1:0]  ringing;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [1:0]  digit;
        logic [3:0]  val;
        logic        mode;
        logic [15:0] exp_time;
        logic [15:0] exp_disp;
        logic        exp_pm;
    } vec_t;

    vec_t vecs [14];

    multi_alarm_clock #(.TICK_DIV(TD), .N_ALARM(2), .SNOOZE_MIN(2)) dut (
        .clk(clk), .rst(rst), .en(en), .mode_12h(mode_12h), .set_time(set_time),
        .set_alarm(set_alarm), .alarm_sel(alarm_sel), .digit_sel(digit_sel),
        .load_val(load_val), .load_strobe(load_strobe), .alarm_arm(alarm_arm),
        .snooze(snooze), .dismiss(dismiss), .time_bcd(time_bcd), .disp_bcd(disp_bcd),
        .pm(pm), .alarm_bcd(alarm_bcd), .ringing(ringing), .buzz(buzz), .sec_tick(sec_tick)
    );

    always #5 clk = ~clk;

    task checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task step();
        @(posedge clk);
        #1;
    endtask

    task writeDigit(input logic [1:0] d, input logic [3:0] v);
        digit_sel   = d;
        load_val    = v;
        load_strobe = 1'b1;
        step();
        load_strobe = 1'b0;
    endtask

    task applyStimulus(input vec_t v);
        mode_12h = v.mode;
        writeDigit(v.digit, v.val);
    endtask

    // Steps clocks until n sec_tick pulses have been consumed; gap is the last tick interval.
    task runTicks(input int n, output int gap, output int cycles);
        int seen;
        int last;
        seen   = 0;
        last   = -1;
        gap    = 0;
        cycles = 0;
        while (seen < n && cycles < n * TD * 2 + 8) begin
            if (sec_tick) begin
                seen++;
                gap  = cycles - last;
                last = cycles;
            end
            step();
            cycles++;
        end
        if (seen < n) begin
            checks++;
            errors++;
            $display("[TB] FAIL tick_timeout: got %0d ticks expected %0d", seen, n);
        end
    endtask

    initial begin
        int gap;
        int cyc;

        vecs = '{
            '{2'd3, 4'd0,  1'b1, 16'h0000, 16'h1200, 1'b0},
            '{2'd2, 4'd5,  1'b0, 16'h0500, 16'h0500, 1'b0},
            '{2'd3, 4'd2,  1'b0, 16'h0500, 16'h0500, 1'b0},
            '{2'd1, 4'd7,  1'b0, 16'h0500, 16'h0500, 1'b0},
            '{2'd1, 4'd3,  1'b0, 16'h0530, 16'h0530, 1'b0},
            '{2'd0, 4'd9,  1'b0, 16'h0539, 16'h0539, 1'b0},
            '{2'd2, 4'd2,  1'b1, 16'h0239, 16'h0239, 1'b0},
            '{2'd3, 4'd1,  1'b1, 16'h1239, 16'h1239, 1'b1},
            '{2'd2, 4'd3,  1'b1, 16'h1339, 16'h0139, 1'b1},
            '{2'd3, 4'd2,  1'b1, 16'h2339, 16'h1139, 1'b1},
            '{2'd0, 4'hA,  1'b0, 16'h2339, 16'h2339, 1'b0},
            '{2'd3, 4'd3,  1'b0, 16'h2339, 16'h2339, 1'b0},
            '{2'd2, 4'd4,  1'b0, 16'h2339, 16'h2339, 1'b0},
            '{2'd3, 4'd0,  1'b1, 16'h0339, 16'h0339, 1'b0}
        };

        rst = 1'b1; en = 1'b0; mode_12h = 1'b0; set_time = 1'b0; set_alarm = 1'b0;
        alarm_sel = 2'd0; digit_sel = 2'd0; load_val = 4'd0; load_strobe = 1'b0;
        alarm_arm = 2'b00; snooze = 1'b0; dismiss = 1'b0;
        step();
        step();
        checkOutput("reset_time", time_bcd, 24'h000000);
        checkOutput("reset_ringing", ringing, 2'b00);
        checkOutput("reset_buzz", buzz, 1'b0);
        checkOutput("reset_sec_tick", sec_tick, 1'b0);
        checkOutput("reset_alarm0", alarm_bcd, 16'h0000);
        rst = 1'b0;
        step();

        set_time = 1'b1;
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d_time", i), time_bcd, {vecs[i].exp_time, 8'h00});
            checkOutput($sformatf("vec%0d_disp", i), disp_bcd, vecs[i].exp_disp);
            checkOutput($sformatf("vec%0d_pm", i), pm, vecs[i].exp_pm);
        end

        mode_12h = 1'b0;
        writeDigit(2'd3, 4'd2);
        writeDigit(2'd2, 4'd3);
        writeDigit(2'd1, 4'd5);
        writeDigit(2'd0, 4'd9);
        checkOutput("load_2359", time_bcd, 24'h235900);
        set_time = 1'b0;
        en = 1'b1;
        runTicks(60, gap, cyc);
        checkOutput("midnight_wrap", time_bcd, 24'h000000);
        checkOutput("tick_period", gap, TD);

        en = 1'b0;
        set_alarm = 1'b1;
        alarm_sel = 2'd1;
        writeDigit(2'd0, 4'd1);
        checkOutput("alarm1_write", alarm_bcd, 16'h0001);
        writeDigit(2'd1, 4'd6);
        checkOutput("alarm1_reject", alarm_bcd, 16'h0001);
        alarm_sel = 2'd2;
        writeDigit(2'd0, 4'd5);
        checkOutput("alarm_sel_oor", alarm_bcd, 16'h0000);
        alarm_sel = 2'd0;
        #1;
        checkOutput("alarm0_untouched", alarm_bcd, 16'h0000);
        repeat (8) step();
        checkOutput("freeze_time", time_bcd, 24'h000000);
        checkOutput("freeze_tick", sec_tick, 1'b0);
        set_alarm = 1'b0;
        alarm_arm = 2'b10;
        en = 1'b1;
        runTicks(59, gap, cyc);
        checkOutput("pre_match_ring", ringing, 2'b00);
        runTicks(1, gap, cyc);
        checkOutput("match_time", time_bcd, 24'h000100);
        checkOutput("match_ring", ringing, 2'b10);
        checkOutput("match_buzz", buzz, 1'b1);
        runTicks(59, gap, cyc);
        checkOutput("ring_59s", ringing, 2'b10);
        runTicks(1, gap, cyc);
        checkOutput("ring_timeout", ringing, 2'b00);
        checkOutput("timeout_buzz", buzz, 1'b0);

        en = 1'b0;
        set_alarm = 1'b1;
        alarm_sel = 2'd0;
        writeDigit(2'd0, 4'd3);
        set_alarm = 1'b0;
        alarm_arm = 2'b01;
        en = 1'b1;
        runTicks(60, gap, cyc);
        checkOutput("a0_time", time_bcd, 24'h000300);
        checkOutput("a0_ring", ringing, 2'b01);
        snooze = 1'b1;
        step();
        snooze = 1'b0;
        checkOutput("a0_snoozed", ringing, 2'b00);
        runTicks(60, gap, cyc);
        checkOutput("snooze_1min", ringing, 2'b00);
        runTicks(60, gap, cyc);
        checkOutput("snooze_time", time_bcd, 24'h000500);
        checkOutput("snooze_rering", ringing, 2'b01);
        snooze = 1'b1;
        dismiss = 1'b1;
        step();
        snooze = 1'b0;
        dismiss = 1'b0;
        checkOutput("dismiss_wins", ringing, 2'b00);
        runTicks(120, gap, cyc);
        checkOutput("stays_idle", ringing, 2'b00);

        en = 1'b0;
        set_alarm = 1'b1;
        alarm_sel = 2'd1;
        writeDigit(2'd0, 4'd8);
        set_alarm = 1'b0;
        alarm_arm = 2'b10;
        en = 1'b1;
        runTicks(60, gap, cyc);
        checkOutput("a1_ring_0800", ringing, 2'b10);
        alarm_arm = 2'b00;
        step();
        checkOutput("disarm", ringing, 2'b00);

        en = 1'b0;
        set_alarm = 1'b1;
        alarm_sel = 2'd0;
        writeDigit(2'd0, 4'd9);
        alarm_sel = 2'd1;
        writeDigit(2'd0, 4'd9);
        set_alarm = 1'b0;
        alarm_arm = 2'b11;
        en = 1'b1;
        runTicks(60, gap, cyc);
        checkOutput("both_time", time_bcd, 24'h000900);
        checkOutput("both_ring", ringing, 2'b11);
        en = 1'b0;
        snooze = 1'b1;
        step();
        snooze = 1'b0;
        checkOutput("both_snooze_en0", ringing, 2'b00);
        en = 1'b1;
        runTicks(120, gap, cyc);
        checkOutput("both_rering_time", time_bcd, 24'h001100);
        checkOutput("both_rering", ringing, 2'b11);

        #3;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_ring", ringing, 2'b00);
        checkOutput("async_rst_time", time_bcd, 24'h000000);
        checkOutput("async_rst_buzz", buzz, 1'b0);
        checkOutput("async_rst_tick", sec_tick, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        runTicks(1, gap, cyc);
        checkOutput("post_rst_latency", cyc, TD);
        checkOutput("post_rst_time", time_bcd, 24'h000001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multi_alarm_clock.md
MULTI_ALARM_CLOCK -- requirements
Module: multi_alarm_clock

Interface
REQ-001 Parameter TICK_DIV, default 50000000, clk cycles per second (legal >= 2).
REQ-002 Parameter N_ALARM, default 2, number of independent alarms (legal 1..4).
REQ-003 Parameter SNOOZE_MIN, default 5, snooze length in minutes (legal 1..9).
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset; asynchronous, active-high.
REQ-006 en  in  1  run enable for timekeeping.
REQ-007 mode_12h  in  1  1 = 12-hour display, 0 = 24-hour display.
REQ-008 set_time  in  1  level; clock load mode.
REQ-009 set_alarm  in  1  level; alarm load mode.
REQ-010 alarm_sel  in  2  alarm index for load and alarm_bcd.
REQ-011 digit_sel  in  2  digit to write: 0 = min ones, 1 = min tens, 2 = hr ones, 3 = hr tens.
REQ-012 load_val  in  4  BCD value to write.
REQ-013 load_strobe  in  1  one-cycle pulse; commits load_val.
REQ-014 alarm_arm  in  N_ALARM  per-alarm arm level.
REQ-015 snooze  in  1  one-cycle pulse.
REQ-016 dismiss  in  1  one-cycle pulse.
REQ-017 time_bcd  out  24  hh:mm:ss BCD, 24-hour format, registered.
REQ-018 disp_bcd  out  16  hh:mm BCD in the selected display mode.
REQ-019 pm  out  1  PM indicator; 0 when mode_12h = 0.
REQ-020 alarm_bcd  out  16  hh:mm of the selected alarm; 0 if alarm_sel >= N_ALARM.
REQ-021 ringing  out  N_ALARM  per-alarm ringing state, registered.
REQ-022 buzz  out  1  OR of ringing.
REQ-023 sec_tick  out  1  one-cycle pulse per elapsed second.

Function
REQ-024 The prescaler SHALL count 0..TICK_DIV-1 while en=1 and set_time=0, pulse sec_tick when at TICK_DIV-1, and wrap to 0; otherwise it holds.
REQ-025 Each sec_tick SHALL advance the BCD seconds; carries ripple to minutes and hours in the same cycle, with 23:59:59 -> 00:00:00.
REQ-026 set_time=1 SHALL clear the prescaler and seconds and hold them at 0; minutes and hours are held except for writes.
REQ-027 A load_strobe with set_time=1 SHALL write load_val to the time digit selected by digit_sel, visible the next cycle.
REQ-028 A load_strobe with set_time=0 and set_alarm=1 SHALL write the selected digit of alarm[alarm_sel]; set_time has priority.
REQ-029 A write SHALL be rejected with no state change if any of these holds: load_val > digit max (9/5/9/2), the resulting hour > 23, or alarm_sel >= N_ALARM.
REQ-030 The 12-hour map SHALL be: hour 0 -> 12 with pm=0; 1-11 -> same with pm=0; 12 -> 12 with pm=1; 13-23 -> hour-12 with pm=1.
REQ-031 Each alarm SHALL have an FSM with states IDLE, RING and SNOOZE; ringing[i] = (state == RING).
REQ-032 IDLE -> RING SHALL occur on the sec_tick that makes time equal to alarm hh:mm:00, when alarm_arm[i]=1.
REQ-033 In RING, dismiss SHALL go to IDLE, snooze SHALL go to SNOOZE and load the counter with SNOOZE_MIN, and 60 sec_ticks without input SHALL auto-return to IDLE.
REQ-034 In SNOOZE, each minute carry SHALL decrement the counter; the carry that reaches 0 goes to RING with a fresh 60 s timeout. dismiss SHALL go to IDLE.
REQ-035 If snooze and dismiss are asserted in the same cycle, dismiss SHALL win.
REQ-036 snooze and dismiss SHALL act on all alarms simultaneously in an applicable state.
REQ-037 alarm_arm[i]=0 SHALL force alarm i to IDLE on the next edge, from any state.
REQ-038 Writing an alarm or the time SHALL NOT alter any FSM state; a match can arise only from a sec_tick.
REQ-039 If en=0, timekeeping and snooze countdowns SHALL freeze, while dismiss, snooze and disarm remain effective.

Reset
REQ-040 rst=1 SHALL asynchronously set time to 00:00:00, all alarms to 00:00, all FSMs to IDLE, the prescaler and snooze counters to 0, and sec_tick, ringing and buzz to 0.
REQ-041 Reset SHALL take effect mid-ring and mid-write; the first count after release begins from prescaler 0.

Verification (TICK_DIV=4, N_ALARM=2, SNOOZE_MIN=2)
REQ-042 Load 23:59 via set_time, release, run 60 sec_ticks -> time_bcd=000000 after the last tick; sec_tick period is 4 clocks.
REQ-043 Write hr tens=2 over hr ones=5, then load_val=7 to min tens -> both writes rejected; hours stay 05, minutes unchanged.
REQ-044 Set alarm1=00:01, arm it, start from 00:00:00 -> ringing=2'b10 and buzz=1 on the tick to 00:01:00; no input for 60 ticks -> IDLE.
REQ-045 Ringing alarm0, snooze pulse -> SNOOZE; 2 minute carries -> RING again; snooze and dismiss in the same cycle -> IDLE.
REQ-046 mode_12h=1 at hours 00, 12, 13 -> disp hours 12/12/01 with pm 0/1/1.
REQ-047 Assert rst during RING -> ringing=0 and time=000000 immediately, without waiting for a clk edge.
